vx_mem_req_arbiter: RTL and testbench
=====================================

Name: vx_mem_req_arbiter

Overview:
- Two-requester arbiter in front of the single Vortex memory-slave port.
- Requester 0 is the Vortex core memory bus; requester 1 is the host/debug port used for program load and memory dump.
- Single-beat requests are granted round-robin into a one-entry output register. A source bit is appended to the downstream tag so responses route back to their requester.
- Read responses are tracked per requester, and requests are throttled at a per-requester outstanding limit.

Parameters:
ADDR_W, 26, memory line address width
DATA_W, 512, memory data width; byte-enable width BE_W = DATA_W/8
TAG_W, 8, requester tag width; downstream tag width is TAG_W+1
MAX_OUTST, 4, maximum outstanding reads per requester (power of 2, at least 1)

Ports:
clk  in  1  clock, rising edge
nRST  in  1  asynchronous active-low reset
cN_req_valid, cN_req_rw (N=0,1)  in  1 each  request valid; rw=1 write
cN_req_byteen  in  BE_W  byte enables
cN_req_addr  in  ADDR_W  line address
cN_req_data  in  DATA_W  write data
cN_req_tag  in  TAG_W  requester tag
cN_req_ready  out  1  request accepted when valid&&ready
cN_rsp_valid  out  1  read response valid
cN_rsp_data  out  DATA_W  read data
cN_rsp_tag  out  TAG_W  returned requester tag
cN_rsp_ready  in  1  requester accepts response
m_req_valid, m_req_rw  out  1 each  downstream request
m_req_byteen / m_req_addr / m_req_data  out  BE_W / ADDR_W / DATA_W  downstream request payload
m_req_tag  out  TAG_W+1  {source id, requester tag}
m_req_ready  in  1  slave accepts request
m_rsp_valid  in  1  slave response valid
m_rsp_data  in  DATA_W  response data
m_rsp_tag  in  TAG_W+1  response tag; MSB is source id
m_rsp_ready  out  1  arbiter accepts response
busy  out  1  output register full, or any read outstanding
rsp_err  out  1  sticky: response arrived for a source with zero reads outstanding

Behaviour:
Reset values:
- All m_req_* outputs are 0; cN_req_ready=0, cN_rsp_valid=0, busy=0, rsp_err=0.
- Round-robin pointer favours c0; both outstanding counters are 0.

Output register (one entry, states EMPTY/FULL):
- EMPTY->FULL on any grant.
- FULL->EMPTY on m_req_valid&&m_req_ready with no new grant.
- FULL->FULL when a new grant coincides with the slave accepting the current entry (back-to-back, full throughput).

Eligibility and grant:
- cN is eligible when cN_req_valid is high and (rw=1 or cnt[N] < MAX_OUTST).
- Grant occurs when the register is EMPTY, or FULL and being accepted this cycle.
- cN_req_ready = grant to N; it is combinational from valid, counts, pointer and m_req_ready.

Arbitration:
- If both requesters are eligible, grant the one the pointer favours.
- After each grant the pointer favours the other requester.
- If only one is eligible, grant it; the pointer still flips.

Latency:
- An accepted request appears on m_req_* on the next cycle.
- The payload is held stable while m_req_valid=1 and m_req_ready=0.

Outstanding counters:
- cnt[N] is clog2(MAX_OUTST)+1 bits wide.
- Increments on a granted read (rw=0) from N.
- Decrements on the handshake m_rsp_valid&&m_rsp_ready with tag MSB=N.
- Simultaneous increment and decrement leaves the count unchanged.
- Writes produce no response and are not counted.

Response routing:
- Source s = m_rsp_tag[TAG_W].
- cs_rsp_valid = m_rsp_valid; cs_rsp_data = m_rsp_data; cs_rsp_tag = m_rsp_tag[TAG_W-1:0].
- m_rsp_ready = cs_rsp_ready; the other requester sees rsp_valid=0.
- Routing is purely combinational: no added latency or buffering.

Error handling:
- A response for source s with cnt[s]=0 sets rsp_err, which stays set until reset.
- The response is still delivered to s and the counter saturates at 0.

busy = register FULL OR cnt[0]!=0 OR cnt[1]!=0.

Reset mid-operation:
- The output register, all counters and rsp_err clear immediately.
- Requests already issued downstream are abandoned; any late responses set rsp_err.

Test Plan:
- Single read: c0 read addr 0x3C0_0000, tag 0x05; slave ready=1 -> m_req_valid one cycle after the grant with m_req_tag=0x005; response tag 0x005 -> c0_rsp_valid, tag 0x05, c1_rsp_valid=0; busy falls after the response.
- Contention: c0 and c1 hold valid reads continuously, m_req_ready=1 -> grants alternate c0,c1,c0,c1 starting with c0 after reset; one request per cycle on m_req.
- Backpressure: m_req_ready=0 for 5 cycles with the register FULL -> payload stable, both cN_req_ready=0; ready returns -> queued grant occurs in the same cycle the entry is accepted.
- Throttle: c1 issues 4 reads with no responses (MAX_OUTST=4) -> 5th c1 read stalls while c1 writes and c0 reads still proceed; one c1 response returns -> the stalled read is granted next cycle.
- Routing stall: response tagged 0x1AA while c1_rsp_ready=0 for 3 cycles -> m_rsp_ready=0 for those cycles; c1 receives tag 0xAA once ready rises; c0 sees nothing.
- Error and reset: response tag 0x011 with cnt[0]=0 -> rsp_err=1 and stays set; nRST asserted asynchronously mid-transaction -> all outputs 0 in the same cycle, rsp_err cleared.

Source files
------------

// File: rtl/vx_mem_req_arbiter.sv
`timescale 1ns/1ps
// vx_mem_req_arbiter
// Two-requester round-robin arbiter in front of the single memory-slave port.
// Requester 0 is the core memory bus, requester 1 the host/debug port.
// Granted single-beat requests land in a one-entry output register. The
// downstream tag is {source id, requester tag}. Read responses are routed back
// combinationally by the tag MSB. Each requester's outstanding reads are
// counted, and its reads are throttled at MAX_OUTST.
//
// Ports:
//   clk, nRST                      clock, asynchronous active-low reset
//   c0_req_* / c1_req_*            requester request channels (valid/ready)
//   c0_rsp_* / c1_rsp_*            requester read-response channels
//   m_req_*                        downstream request (tag is TAG_W+1 bits)
//   m_rsp_*                        downstream response (tag MSB = source id)
//   busy                           output register full or any read outstanding
//   rsp_err                        sticky: response for a source with none outstanding
module vx_mem_req_arbiter #(
  parameter int ADDR_W    = 26,
  parameter int DATA_W    = 512,
  parameter int TAG_W     = 8,
  parameter int MAX_OUTST = 4,
  localparam int BE_W     = DATA_W / 8
) (
  input  logic              clk,
  input  logic              nRST,

  input  logic              c0_req_valid,
  input  logic              c0_req_rw,
  input  logic [BE_W-1:0]   c0_req_byteen,
  input  logic [ADDR_W-1:0] c0_req_addr,
  input  logic [DATA_W-1:0] c0_req_data,
  input  logic [TAG_W-1:0]  c0_req_tag,
  output logic              c0_req_ready,
  output logic              c0_rsp_valid,
  output logic [DATA_W-1:0] c0_rsp_data,
  output logic [TAG_W-1:0]  c0_rsp_tag,
  input  logic              c0_rsp_ready,

  input  logic              c1_req_valid,
  input  logic              c1_req_rw,
  input  logic [BE_W-1:0]   c1_req_byteen,
  input  logic [ADDR_W-1:0] c1_req_addr,
  input  logic [DATA_W-1:0] c1_req_data,
  input  logic [TAG_W-1:0]  c1_req_tag,
  output logic              c1_req_ready,
  output logic              c1_rsp_valid,
  output logic [DATA_W-1:0] c1_rsp_data,
  output logic [TAG_W-1:0]  c1_rsp_tag,
  input  logic              c1_rsp_ready,

  output logic              m_req_valid,
  output logic              m_req_rw,
  output logic [BE_W-1:0]   m_req_byteen,
  output logic [ADDR_W-1:0] m_req_addr,
  output logic [DATA_W-1:0] m_req_data,
  output logic [TAG_W:0]    m_req_tag,
  input  logic              m_req_ready,
  input  logic              m_rsp_valid,
  input  logic [DATA_W-1:0] m_rsp_data,
  input  logic [TAG_W:0]    m_rsp_tag,
  output logic              m_rsp_ready,

  output logic              busy,
  output logic              rsp_err
);

  localparam int CNT_W = $clog2(MAX_OUTST) + 1;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTST);

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } occ_e;

  // Outstanding-read counter update; a decrement at zero saturates (the
  // error flag records the event separately).
  function automatic logic [CNT_W-1:0] cnt_update(input logic [CNT_W-1:0] cnt,
                                                  input logic inc,
                                                  input logic dec);
    logic [CNT_W-1:0] res;
    res = cnt;
    if (inc && !dec) begin
      res = cnt + CNT_W'(1);
    end else if (dec && !inc) begin
      res = (cnt == '0) ? '0 : cnt - CNT_W'(1);
    end
    return res;
  endfunction

  occ_e              occ_p1, occ_nxt;
  logic              rr_p1;          // 0: c0 favoured, 1: c1 favoured
  logic [CNT_W-1:0]  cnt0_p1, cnt1_p1;
  logic              rsp_err_p1;
  logic              req_rw_p1;
  logic [BE_W-1:0]   req_byteen_p1;
  logic [ADDR_W-1:0] req_addr_p1;
  logic [DATA_W-1:0] req_data_p1;
  logic [TAG_W:0]    req_tag_p1;

  logic vld_p1;
  logic accept_p0, slot_free_p0;
  logic elig0_p0, elig1_p0;
  logic gnt0_p0, gnt1_p0, any_gnt_p0;
  logic rsp_src, rsp_fire, dec0, dec1, inc0, inc1, err_hit;

  // ---- Stage p0: eligibility and grant (combinational) ----
  assign vld_p1       = (occ_p1 == S_FULL);
  assign accept_p0    = vld_p1 && m_req_ready;
  assign slot_free_p0 = !vld_p1 || accept_p0;
  assign elig0_p0     = c0_req_valid && (c0_req_rw || (cnt0_p1 < MAX_CNT));
  assign elig1_p0     = c1_req_valid && (c1_req_rw || (cnt1_p1 < MAX_CNT));

  // Ready is suppressed while reset is held so nothing is granted then.
  always_comb begin
    gnt0_p0 = 1'b0;
    gnt1_p0 = 1'b0;
    if (nRST && slot_free_p0) begin
      if (elig0_p0 && elig1_p0) begin
        gnt0_p0 = !rr_p1;
        gnt1_p0 = rr_p1;
      end else begin
        gnt0_p0 = elig0_p0;
        gnt1_p0 = elig1_p0;
      end
    end
  end

  assign any_gnt_p0   = gnt0_p0 || gnt1_p0;
  assign c0_req_ready = gnt0_p0;
  assign c1_req_ready = gnt1_p0;

  always_comb begin
    occ_nxt = occ_p1;
    case (occ_p1)
      S_EMPTY: if (any_gnt_p0) occ_nxt = S_FULL;
      S_FULL:  if (accept_p0 && !any_gnt_p0) occ_nxt = S_EMPTY;
      default: occ_nxt = S_EMPTY;
    endcase
  end

  // ---- Stage p1: output register ----
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      occ_p1 <= S_EMPTY;
      rr_p1  <= 1'b0;
    end else begin
      occ_p1 <= occ_nxt;
      if (any_gnt_p0) rr_p1 <= !rr_p1;
    end
  end

  // Payload is also cleared so the downstream port reads all-zero in reset.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      req_rw_p1     <= 1'b0;
      req_byteen_p1 <= '0;
      req_addr_p1   <= '0;
      req_data_p1   <= '0;
      req_tag_p1    <= '0;
    end else if (any_gnt_p0) begin
      req_rw_p1     <= gnt1_p0 ? c1_req_rw     : c0_req_rw;
      req_byteen_p1 <= gnt1_p0 ? c1_req_byteen : c0_req_byteen;
      req_addr_p1   <= gnt1_p0 ? c1_req_addr   : c0_req_addr;
      req_data_p1   <= gnt1_p0 ? c1_req_data   : c0_req_data;
      req_tag_p1    <= {gnt1_p0, (gnt1_p0 ? c1_req_tag : c0_req_tag)};
    end
  end

  assign m_req_valid  = vld_p1;
  assign m_req_rw     = req_rw_p1;
  assign m_req_byteen = req_byteen_p1;
  assign m_req_addr   = req_addr_p1;
  assign m_req_data   = req_data_p1;
  assign m_req_tag    = req_tag_p1;

  // ---- Response routing and outstanding tracking ----
  assign rsp_src      = m_rsp_tag[TAG_W];
  assign c0_rsp_valid = nRST && m_rsp_valid && !rsp_src;
  assign c1_rsp_valid = nRST && m_rsp_valid && rsp_src;
  assign c0_rsp_data  = m_rsp_data;
  assign c1_rsp_data  = m_rsp_data;
  assign c0_rsp_tag   = m_rsp_tag[TAG_W-1:0];
  assign c1_rsp_tag   = m_rsp_tag[TAG_W-1:0];
  assign m_rsp_ready  = nRST && (rsp_src ? c1_rsp_ready : c0_rsp_ready);

  assign rsp_fire = m_rsp_valid && m_rsp_ready;
  assign dec0     = rsp_fire && !rsp_src;
  assign dec1     = rsp_fire && rsp_src;
  assign inc0     = gnt0_p0 && !c0_req_rw;
  assign inc1     = gnt1_p0 && !c1_req_rw;
  assign err_hit  = (dec0 && (cnt0_p1 == '0)) || (dec1 && (cnt1_p1 == '0));

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      cnt0_p1    <= '0;
      cnt1_p1    <= '0;
      rsp_err_p1 <= 1'b0;
    end else begin
      cnt0_p1 <= cnt_update(cnt0_p1, inc0, dec0);
      cnt1_p1 <= cnt_update(cnt1_p1, inc1, dec1);
      if (err_hit) rsp_err_p1 <= 1'b1;
    end
  end

  assign rsp_err = rsp_err_p1;
  assign busy    = vld_p1 || (cnt0_p1 != '0) || (cnt1_p1 != '0);

endmodule

// File: tb/tb_vx_mem_req_arbiter.sv
`timescale 1ns/1ps
module tb_vx_mem_req_arbiter;

  localparam int ADDR_W = 26;
  localparam int DATA_W = 512;
  localparam int TAG_W  = 8;
  localparam int MAX_OUTST = 4;
  localparam int BE_W   = DATA_W / 8;

  logic clk = 1'b0;
  logic nRST;
  always #5 clk = ~clk;

  logic              c0_req_valid, c0_req_rw, c0_req_ready;
  logic [BE_W-1:0]   c0_req_byteen;
  logic [ADDR_W-1:0] c0_req_addr;
  logic [DATA_W-1:0] c0_req_data;
  logic [TAG_W-1:0]  c0_req_tag;
  logic              c0_rsp_valid, c0_rsp_ready;
  logic [DATA_W-1:0] c0_rsp_data;
  logic [TAG_W-1:0]  c0_rsp_tag;
  logic              c1_req_valid, c1_req_rw, c1_req_ready;
  logic [BE_W-1:0]   c1_req_byteen;
  logic [ADDR_W-1:0] c1_req_addr;
  logic [DATA_W-1:0] c1_req_data;
  logic [TAG_W-1:0]  c1_req_tag;
  logic              c1_rsp_valid, c1_rsp_ready;
  logic [DATA_W-1:0] c1_rsp_data;
  logic [TAG_W-1:0]  c1_rsp_tag;
  logic              m_req_valid, m_req_rw, m_req_ready;
  logic [BE_W-1:0]   m_req_byteen;
  logic [ADDR_W-1:0] m_req_addr;
  logic [DATA_W-1:0] m_req_data;
  logic [TAG_W:0]    m_req_tag;
  logic              m_rsp_valid, m_rsp_ready;
  logic [DATA_W-1:0] m_rsp_data;
  logic [TAG_W:0]    m_rsp_tag;
  logic              busy, rsp_err;

  vx_mem_req_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_W(TAG_W), .MAX_OUTST(MAX_OUTST)) dut (
    .clk(clk), .nRST(nRST),
    .c0_req_valid(c0_req_valid), .c0_req_rw(c0_req_rw), .c0_req_byteen(c0_req_byteen),
    .c0_req_addr(c0_req_addr), .c0_req_data(c0_req_data), .c0_req_tag(c0_req_tag),
    .c0_req_ready(c0_req_ready), .c0_rsp_valid(c0_rsp_valid), .c0_rsp_data(c0_rsp_data),
    .c0_rsp_tag(c0_rsp_tag), .c0_rsp_ready(c0_rsp_ready),
    .c1_req_valid(c1_req_valid), .c1_req_rw(c1_req_rw), .c1_req_byteen(c1_req_byteen),
    .c1_req_addr(c1_req_addr), .c1_req_data(c1_req_data), .c1_req_tag(c1_req_tag),
    .c1_req_ready(c1_req_ready), .c1_rsp_valid(c1_rsp_valid), .c1_rsp_data(c1_rsp_data),
    .c1_rsp_tag(c1_rsp_tag), .c1_rsp_ready(c1_rsp_ready),
    .m_req_valid(m_req_valid), .m_req_rw(m_req_rw), .m_req_byteen(m_req_byteen),
    .m_req_addr(m_req_addr), .m_req_data(m_req_data), .m_req_tag(m_req_tag),
    .m_req_ready(m_req_ready), .m_rsp_valid(m_rsp_valid), .m_rsp_data(m_rsp_data),
    .m_rsp_tag(m_rsp_tag), .m_rsp_ready(m_rsp_ready),
    .busy(busy), .rsp_err(rsp_err)
  );

  typedef struct {
    logic              rw;
    logic [BE_W-1:0]   be;
    logic [ADDR_W-1:0] addr;
    logic [TAG_W:0]    tag;
    logic [DATA_W-1:0] data;
  } req_t;

  typedef struct {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } rsp_t;

  req_t q0[$], q1[$], exp_req[$];
  rsp_t exp_rsp0[$], exp_rsp1[$];
  int checks = 0;
  int failures = 0;

  function automatic logic [DATA_W-1:0] mkdata(input logic [TAG_W:0] t);
    return {16{{23'h5A5A5A, t}}};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_data(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got ...%08h expected ...%08h", name, act[31:0], exp[31:0]);
    end
  endtask

  // Queue a request on requester src and record the downstream beat it must produce.
  task automatic add_req(input logic src, input logic rw, input logic [ADDR_W-1:0] addr,
                         input logic [TAG_W-1:0] tag);
    req_t r;
    r.rw   = rw;
    r.be   = {8{tag}};
    r.addr = addr;
    r.tag  = {src, tag};
    r.data = mkdata({src, tag});
    if (src) q1.push_back(r);
    else     q0.push_back(r);
    exp_req.push_back(r);
  endtask

  task automatic wait_exp(input int n, input string name);
    bit ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (exp_req.size() <= n) begin ok = 1; break; end
    end
    chk({name, "_drain"}, 64'(ok), 64'd1);
  endtask

  task automatic wait_mvalid(input string name);
    bit ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (m_req_valid) begin ok = 1; break; end
    end
    chk({name, "_mvalid"}, 64'(ok), 64'd1);
  endtask

  task automatic rst_pulse();
    @(negedge clk);
    nRST = 1'b0;
    @(negedge clk);
    nRST = 1'b1;
  endtask

  task automatic drive_rsp(input logic [TAG_W:0] tag, input logic [DATA_W-1:0] data);
    @(posedge clk); #1;
    m_rsp_valid = 1'b1;
    m_rsp_tag   = tag;
    m_rsp_data  = data;
  endtask

  task automatic drop_rsp();
    @(posedge clk); #1;
    m_rsp_valid = 1'b0;
  endtask

  // Requester drivers: present the queue head, hold it until the handshake.
  initial begin : drv0
    c0_req_valid = 0; c0_req_rw = 0; c0_req_byteen = '0;
    c0_req_addr = '0; c0_req_data = '0; c0_req_tag = '0;
    forever begin
      @(negedge clk);
      if (c0_req_valid && c0_req_ready && q0.size() > 0) void'(q0.pop_front());
      @(posedge clk); #1;
      if (nRST && q0.size() > 0) begin
        c0_req_valid = 1'b1; c0_req_rw = q0[0].rw; c0_req_byteen = q0[0].be;
        c0_req_addr = q0[0].addr; c0_req_data = q0[0].data; c0_req_tag = q0[0].tag[TAG_W-1:0];
      end else begin
        c0_req_valid = 1'b0;
      end
    end
  end

  initial begin : drv1
    c1_req_valid = 0; c1_req_rw = 0; c1_req_byteen = '0;
    c1_req_addr = '0; c1_req_data = '0; c1_req_tag = '0;
    forever begin
      @(negedge clk);
      if (c1_req_valid && c1_req_ready && q1.size() > 0) void'(q1.pop_front());
      @(posedge clk); #1;
      if (nRST && q1.size() > 0) begin
        c1_req_valid = 1'b1; c1_req_rw = q1[0].rw; c1_req_byteen = q1[0].be;
        c1_req_addr = q1[0].addr; c1_req_data = q1[0].data; c1_req_tag = q1[0].tag[TAG_W-1:0];
      end else begin
        c1_req_valid = 1'b0;
      end
    end
  end

  // Downstream request monitor
  always @(negedge clk) begin : mon_req
    req_t e;
    if (nRST && m_req_valid && m_req_ready) begin
      if (exp_req.size() == 0) begin
        checks++; failures++;
        $display("FAIL m_req_unexpected: got tag %0h expected none", m_req_tag);
      end else begin
        e = exp_req.pop_front();
        chk("m_req_tag", 64'(m_req_tag), 64'(e.tag));
        chk("m_req_rw", 64'(m_req_rw), 64'(e.rw));
        chk("m_req_addr", 64'(m_req_addr), 64'(e.addr));
        chk("m_req_byteen", m_req_byteen, e.be);
        chk_data("m_req_data", m_req_data, e.data);
      end
    end
  end

  // Response monitors
  always @(negedge clk) begin : mon_rsp0
    rsp_t e;
    if (c0_rsp_valid && c0_rsp_ready) begin
      if (exp_rsp0.size() == 0) begin
        checks++; failures++;
        $display("FAIL c0_rsp_unexpected: got tag %0h expected none", c0_rsp_tag);
      end else begin
        e = exp_rsp0.pop_front();
        chk("c0_rsp_tag", 64'(c0_rsp_tag), 64'(e.tag));
        chk_data("c0_rsp_data", c0_rsp_data, e.data);
      end
    end
  end

  always @(negedge clk) begin : mon_rsp1
    rsp_t e;
    if (c1_rsp_valid && c1_rsp_ready) begin
      if (exp_rsp1.size() == 0) begin
        checks++; failures++;
        $display("FAIL c1_rsp_unexpected: got tag %0h expected none", c1_rsp_tag);
      end else begin
        e = exp_rsp1.pop_front();
        chk("c1_rsp_tag", 64'(c1_rsp_tag), 64'(e.tag));
        chk_data("c1_rsp_data", c1_rsp_data, e.data);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [DATA_W-1:0] d;
    bit ok;
    rsp_t r;
    nRST = 1'b0; m_req_ready = 1'b0; m_rsp_valid = 1'b0; m_rsp_tag = '0; m_rsp_data = '0;
    c0_rsp_ready = 1'b1; c1_rsp_ready = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_m_req_valid", 64'(m_req_valid), 64'd0);
    chk("rst_m_req_rw", 64'(m_req_rw), 64'd0);
    chk("rst_m_req_addr", 64'(m_req_addr), 64'd0);
    chk("rst_m_req_tag", 64'(m_req_tag), 64'd0);
    chk("rst_m_req_data", m_req_data[63:0], 64'd0);
    chk("rst_c0_req_ready", 64'(c0_req_ready), 64'd0);
    chk("rst_c1_req_ready", 64'(c1_req_ready), 64'd0);
    chk("rst_c0_rsp_valid", 64'(c0_rsp_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_rsp_err", 64'(rsp_err), 64'd0);
    nRST = 1'b1;

    // Single read from c0
    m_req_ready = 1'b1;
    @(negedge clk);
    add_req(1'b0, 1'b0, 26'h3C0_0000, 8'h05);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (c0_req_valid && c0_req_ready) begin ok = 1; break; end
    end
    chk("t1_grant", 64'(ok), 64'd1);
    @(negedge clk);
    chk("t1_m_req_valid", 64'(m_req_valid), 64'd1);
    chk("t1_m_req_tag", 64'(m_req_tag), 64'h005);
    chk("t1_m_req_addr", 64'(m_req_addr), 64'h3C0_0000);
    chk("t1_busy_full", 64'(busy), 64'd1);
    @(negedge clk);
    chk("t1_m_req_empty", 64'(m_req_valid), 64'd0);
    chk("t1_busy_outst", 64'(busy), 64'd1);
    d = mkdata(9'h0F5);
    r.tag = 8'h05; r.data = d; exp_rsp0.push_back(r);
    drive_rsp(9'h005, d);
    @(negedge clk);
    chk("t1_c0_rsp_valid", 64'(c0_rsp_valid), 64'd1);
    chk("t1_c1_rsp_valid", 64'(c1_rsp_valid), 64'd0);
    chk("t1_m_rsp_ready", 64'(m_rsp_ready), 64'd1);
    drop_rsp();
    @(negedge clk);
    chk("t1_busy_done", 64'(busy), 64'd0);
    chk("t1_rsp_err", 64'(rsp_err), 64'd0);

    // Contention: alternating grants starting with c0
    rst_pulse();
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      add_req(1'b0, 1'b0, 26'h100 + 26'(i), 8'h10 + 8'(i));
      add_req(1'b1, 1'b0, 26'h200 + 26'(i), 8'h20 + 8'(i));
    end
    wait_mvalid("t2");
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      chk("t2_back_to_back", 64'(m_req_valid), 64'd1);
    end
    @(negedge clk);
    chk("t2_m_req_idle", 64'(m_req_valid), 64'd0);
    chk("t2_all_issued", 64'(exp_req.size()), 64'd0);
    chk("t2_busy", 64'(busy), 64'd1);

    // Backpressure
    rst_pulse();
    m_req_ready = 1'b0;
    @(negedge clk);
    add_req(1'b0, 1'b0, 26'h100, 8'h11);
    add_req(1'b1, 1'b1, 26'h200, 8'h22);
    wait_mvalid("t3");
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      chk("t3_hold_valid", 64'(m_req_valid), 64'd1);
      chk("t3_hold_tag", 64'(m_req_tag), 64'h011);
      chk("t3_hold_addr", 64'(m_req_addr), 64'h100);
      chk("t3_c0_ready", 64'(c0_req_ready), 64'd0);
      chk("t3_c1_ready", 64'(c1_req_ready), 64'd0);
    end
    @(posedge clk); #1;
    m_req_ready = 1'b1;
    @(negedge clk);
    chk("t3_queued_grant", 64'(c1_req_ready), 64'd1);
    @(negedge clk);
    chk("t3_next_tag", 64'(m_req_tag), 64'h122);
    chk("t3_next_rw", 64'(m_req_rw), 64'd1);
    wait_exp(0, "t3");

    // Throttle c1 at MAX_OUTST reads
    rst_pulse();
    @(negedge clk);
    for (int i = 0; i < 4; i++) add_req(1'b1, 1'b0, 26'h300 + 26'(i), 8'h40 + 8'(i));
    wait_exp(0, "t4_reads");
    @(negedge clk);
    add_req(1'b1, 1'b1, 26'h310, 8'h50);
    wait_exp(0, "t4_write");
    @(negedge clk);
    add_req(1'b0, 1'b0, 26'h320, 8'h60);
    add_req(1'b1, 1'b0, 26'h304, 8'h44);
    wait_exp(1, "t4_c0_read");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t4_stall_valid", 64'(c1_req_valid), 64'd1);
      chk("t4_stall_ready", 64'(c1_req_ready), 64'd0);
      chk("t4_stall_m_idle", 64'(m_req_valid), 64'd0);
    end
    d = mkdata(9'h1E0);
    r.tag = 8'h40; r.data = d; exp_rsp1.push_back(r);
    drive_rsp(9'h140, d);
    @(negedge clk);
    chk("t4_still_stalled", 64'(c1_req_ready), 64'd0);
    chk("t4_c0_rsp_valid", 64'(c0_rsp_valid), 64'd0);
    drop_rsp();
    @(negedge clk);
    chk("t4_released", 64'(c1_req_ready), 64'd1);
    @(negedge clk);
    chk("t4_released_tag", 64'(m_req_tag), 64'h144);
    wait_exp(0, "t4_final");

    // Response routing stall
    rst_pulse();
    @(negedge clk);
    add_req(1'b1, 1'b0, 26'h3C0, 8'hAA);
    wait_exp(0, "t5");
    c1_rsp_ready = 1'b0;
    d = mkdata(9'h1AA);
    drive_rsp(9'h1AA, d);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t5_m_rsp_ready", 64'(m_rsp_ready), 64'd0);
      chk("t5_c1_rsp_valid", 64'(c1_rsp_valid), 64'd1);
      chk("t5_c0_rsp_valid", 64'(c0_rsp_valid), 64'd0);
    end
    @(posedge clk); #1;
    r.tag = 8'hAA; r.data = d; exp_rsp1.push_back(r);
    c1_rsp_ready = 1'b1;
    @(negedge clk);
    chk("t5_m_rsp_ready_up", 64'(m_rsp_ready), 64'd1);
    chk("t5_c1_rsp_tag", 64'(c1_rsp_tag), 64'hAA);
    drop_rsp();
    @(negedge clk);
    chk("t5_delivered", 64'(exp_rsp1.size()), 64'd0);
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_rsp_err", 64'(rsp_err), 64'd0);

    // Error: response for c0 with nothing outstanding
    d = mkdata(9'h011);
    r.tag = 8'h11; r.data = d; exp_rsp0.push_back(r);
    drive_rsp(9'h011, d);
    @(negedge clk);
    chk("t6_err_pre", 64'(rsp_err), 64'd0);
    chk("t6_delivered", 64'(c0_rsp_valid), 64'd1);
    drop_rsp();
    @(negedge clk);
    chk("t6_err_set", 64'(rsp_err), 64'd1);
    repeat (3) @(negedge clk);
    chk("t6_err_sticky", 64'(rsp_err), 64'd1);
    chk("t6_busy_saturated", 64'(busy), 64'd0);

    // Asynchronous reset mid-transaction
    m_req_ready = 1'b0;
    @(negedge clk);
    add_req(1'b0, 1'b0, 26'h3C0_0001, 8'h07);
    wait_mvalid("t6");
    chk("t6_busy_before", 64'(busy), 64'd1);
    @(posedge clk); #3;
    nRST = 1'b0;
    #1;
    chk("t6_rst_m_req_valid", 64'(m_req_valid), 64'd0);
    chk("t6_rst_m_req_tag", 64'(m_req_tag), 64'd0);
    chk("t6_rst_m_req_addr", 64'(m_req_addr), 64'd0);
    chk("t6_rst_busy", 64'(busy), 64'd0);
    chk("t6_rst_rsp_err", 64'(rsp_err), 64'd0);
    chk("t6_rst_c0_ready", 64'(c0_req_ready), 64'd0);
    chk("t6_rst_c1_ready", 64'(c1_req_ready), 64'd0);
    exp_req.delete();
    @(negedge clk);
    nRST = 1'b1;
    m_req_ready = 1'b1;
    d = mkdata(9'h005);
    r.tag = 8'h05; r.data = d; exp_rsp0.push_back(r);
    drive_rsp(9'h005, d);
    @(negedge clk);
    chk("t6_late_rsp_valid", 64'(c0_rsp_valid), 64'd1);
    drop_rsp();
    @(negedge clk);
    chk("t6_late_rsp_err", 64'(rsp_err), 64'd1);

    repeat (2) @(negedge clk);
    chk("end_exp_req", 64'(exp_req.size()), 64'd0);
    chk("end_exp_rsp0", 64'(exp_rsp0.size()), 64'd0);
    chk("end_exp_rsp1", 64'(exp_rsp1.size()), 64'd0);
    chk("end_q0", 64'(q0.size()), 64'd0);
    chk("end_q1", 64'(q1.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
